// File: rtl/peripheral_spram_arbiter_axi4.sv
// AXI4 slave that time-shares one SPRAM port between round-robin arbitrated write and read bursts.
// Optional PERIPHERAL_SPRAM_ARBITER_DECERR_EN: out-of-range addresses answer DECERR and never touch the RAM.
module peripheral_spram_arbiter_axi4 #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [3:0]            awid,
   input  logic [31:0]           awadr,
   input  logic [3:0]            awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [3:0]            wid,
   input  logic [31:0]           wrdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [3:0]            bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready,
   input  logic [3:0]            arid,
   input  logic [31:0]           araddr,
   input  logic [3:0]            arlen,
   input  logic [2:0]            arsize,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [3:0]            rid,
   output logic [31:0]           rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   output logic                  ram_ce,
   output logic                  ram_we,
   output logic [3:0]            ram_be,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout,
   output logic [2:0]            state_dbg
);

   // A transfer happens on the aclk edge where valid and ready are both high; valid and payload
   // never look at the same channel's ready, and B/R payloads hold steady until accepted.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WDATA = 3'd1,
      S_WRESP = 3'd2,
      S_RADDR = 3'd3,
      S_RCAP  = 3'd4,
      S_RDATA = 3'd5
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   state_t                state_q, state_d;
   logic                  last_w_q;
   logic [3:0]            id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [3:0]            len_q;
   logic [3:0]            beat_q;
   logic                  fixed_q;
   logic [1:0]            err_q;
   logic [31:0]           rdata_q;

   logic grant_w, aw_hs, ar_hs, w_beat, w_end, r_done, beat_is_len, ram_block;
   logic aw_dec, ar_dec;
   logic unused_ok;

`ifdef PERIPHERAL_SPRAM_ARBITER_DECERR_EN
   assign aw_dec = |awadr[31:ADDR_WIDTH+2];
   assign ar_dec = |araddr[31:ADDR_WIDTH+2];
`else
   assign aw_dec = 1'b0;
   assign ar_dec = 1'b0;
`endif

   assign unused_ok = ^{awsize, arsize, wid, awadr[31:ADDR_WIDTH+2], awadr[1:0],
                        araddr[31:ADDR_WIDTH+2], araddr[1:0]};

   // On a tie the channel that was not served last wins; last_w_q=0 means read went last.
   assign grant_w     = awvalid && (!arvalid || !last_w_q);
   assign aw_hs       = (state_q == S_IDLE) && grant_w;
   assign ar_hs       = (state_q == S_IDLE) && arvalid && !grant_w;
   assign beat_is_len = (beat_q == len_q);
   assign w_beat      = (state_q == S_WDATA) && wvalid;
   assign w_end       = w_beat && (beat_is_len || wlast);
   assign r_done      = (state_q == S_RDATA) && rready;
   assign ram_block   = (err_q == RESP_DECERR);
   assign state_dbg   = state_q;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (aw_hs)      state_d = S_WDATA;
            else if (ar_hs) state_d = S_RADDR;
         end
         S_WDATA: if (w_end)  state_d = S_WRESP;
         S_WRESP: if (bready) state_d = S_IDLE;
         S_RADDR: state_d = S_RCAP;
         S_RCAP:  state_d = S_RDATA;
         S_RDATA: if (rready) state_d = beat_is_len ? S_IDLE : S_RADDR;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      awready  = 1'b0;
      arready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      bid      = '0;
      bresp    = '0;
      rvalid   = 1'b0;
      rid      = '0;
      rdata    = '0;
      rresp    = '0;
      rlast    = 1'b0;
      ram_ce   = 1'b0;
      ram_we   = 1'b0;
      ram_be   = '0;
      ram_addr = '0;
      ram_din  = '0;
      case (state_q)
         S_IDLE: begin
            // Gated so the address readys read 0 for the whole time areset is high.
            awready = !areset && awvalid && grant_w;
            arready = !areset && arvalid && !grant_w;
         end
         S_WDATA: begin
            wready = 1'b1;
            if (wvalid && !ram_block) begin
               ram_ce   = 1'b1;
               ram_we   = 1'b1;
               ram_be   = wstrb;
               ram_din  = wrdata;
               ram_addr = addr_q;
            end
         end
         S_WRESP: begin
            bvalid = 1'b1;
            bid    = id_q;
            bresp  = err_q;
         end
         S_RADDR: begin
            if (!ram_block) begin
               ram_ce   = 1'b1;
               ram_addr = addr_q;
            end
         end
         S_RDATA: begin
            rvalid = 1'b1;
            rid    = id_q;
            rdata  = rdata_q;
            rresp  = err_q;
            rlast  = beat_is_len;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         last_w_q <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         fixed_q  <= 1'b0;
         err_q    <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         if (aw_hs) begin
            id_q    <= awid;
            addr_q  <= awadr[ADDR_WIDTH+1:2];
            len_q   <= awlen;
            fixed_q <= (awburst == 2'b00);
            beat_q  <= '0;
            err_q   <= aw_dec ? RESP_DECERR : RESP_OKAY;
         end else if (ar_hs) begin
            id_q    <= arid;
            addr_q  <= araddr[ADDR_WIDTH+1:2];
            len_q   <= arlen;
            fixed_q <= 1'b0;
            beat_q  <= '0;
            err_q   <= ar_dec ? RESP_DECERR : RESP_OKAY;
         end
         if (w_beat) begin
            if (!fixed_q) addr_q <= addr_q + 1'b1;
            beat_q <= beat_q + 4'd1;
            // Burst closes on the earlier of wlast and the last counted beat; disagreement is SLVERR.
            if (w_end && (wlast != beat_is_len) && !ram_block) err_q <= RESP_SLVERR;
         end
         if ((state_q == S_WRESP) && bready) last_w_q <= 1'b1;
         if (state_q == S_RCAP) rdata_q <= ram_block ? 32'h0 : ram_dout;
         if (r_done) begin
            if (beat_is_len) begin
               last_w_q <= 1'b0;
            end else begin
               addr_q <= addr_q + 1'b1;
               beat_q <= beat_q + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_peripheral_spram_arbiter_axi4.sv
// Bench for peripheral_spram_arbiter_axi4: table of bursts plus arbitration and mid-burst reset sequences.
// Expectations follow PERIPHERAL_SPRAM_ARBITER_DECERR_EN when it is defined.
module tb_peripheral_spram_arbiter_axi4;
   localparam int AW = 8;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef PERIPHERAL_SPRAM_ARBITER_DECERR_EN
   localparam logic [1:0] HI_RESP = 2'b11;
`else
   localparam logic [1:0] HI_RESP = 2'b00;
`endif

   typedef struct {
      bit          wr;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [1:0]  burst;
      logic [3:0]  wlast_at;
      logic [31:0] data0;
      logic [3:0]  strb;
      int          stall;
      logic [1:0]  exp_resp;
   } vec_t;

   logic aclk = 1'b0;
   logic areset;
   logic [3:0] awid, wid, bid, arid, rid;
   logic [31:0] awadr, wrdata, araddr, rdata, ram_din, ram_dout;
   logic [3:0] awlen, wstrb, arlen, ram_be;
   logic [2:0] awsize, arsize, state_dbg;
   logic [1:0] awburst, bresp, rresp;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic arvalid, arready, rlast, rvalid, rready, ram_ce, ram_we;
   logic [AW-1:0] ram_addr;

   logic [31:0] mem [0:255];
   logic [31:0] exp_mem [0:255];
   logic [43:0] exp_w_q[$];
   logic [38:0] exp_r_q[$];
   logic [5:0]  exp_b_q[$];
   int checks = 0, failures = 0, cyc = 0, rd_ce_cnt = 0;
   vec_t vecs[11];

   logic [49:0] hs_outs;
   logic [45:0] ram_outs;
   assign hs_outs  = {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rlast, rdata};
   assign ram_outs = {ram_ce, ram_we, ram_be, ram_addr, ram_din};

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   peripheral_spram_arbiter_axi4 #(.ADDR_WIDTH(AW)) dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
      .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout), .state_dbg(state_dbg)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      merge = old;
      for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic bit addr_dec(input logic [31:0] a);
`ifdef PERIPHERAL_SPRAM_ARBITER_DECERR_EN
      return |a[31:AW+2];
`else
      return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   // SPRAM model: byte-enabled write, one-cycle registered read.
   always @(posedge aclk) begin
      if (ram_ce) begin
         if (ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_din, ram_be);
         else        ram_dout <= mem[ram_addr];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: RAM writes, B and R beats are popped as the DUT produces them.
   initial forever begin
      @(negedge aclk);
      #2;
      if (ram_ce && !ram_we) rd_ce_cnt++;
      if (ram_ce && ram_we) begin
         if (exp_w_q.size() == 0) check("ram_write_unexpected", {ram_addr, ram_be, ram_din}, 44'h0);
         else check("ram_write", {ram_addr, ram_be, ram_din}, exp_w_q.pop_front());
      end
      if (bvalid && bready) begin
         if (exp_b_q.size() == 0) check("b_unexpected", {bid, bresp}, 6'h0);
         else check("b_resp", {bid, bresp}, exp_b_q.pop_front());
      end
      if (rvalid && rready) begin
         if (exp_r_q.size() == 0) check("r_unexpected", {rid, rdata, rresp, rlast}, 39'h0);
         else check("r_beat", {rid, rdata, rresp, rlast}, exp_r_q.pop_front());
      end
   end

   task automatic do_write(input vec_t v);
      int k, nb;
      bit dec;
      logic [7:0] base, wa;
      logic [31:0] d;
      dec  = addr_dec(v.addr);
      base = v.addr[9:2];
      nb   = (v.wlast_at < v.len) ? int'(v.wlast_at) + 1 : int'(v.len) + 1;
      exp_b_q.push_back({v.id, v.exp_resp});
      @(negedge aclk);
      awid = v.id; awadr = v.addr; awlen = v.len; awburst = v.burst; awvalid = 1'b1;
      #1; k = 0;
      while (!awready && k < 20) begin @(negedge aclk); #1; k++; end
      check("aw_handshake", awready, 1);
      @(negedge aclk);
      awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         wa = (v.burst == 2'b00) ? base : base + 8'(i);
         d  = v.data0 + 32'(i);
         wvalid = 1'b1; wrdata = d; wstrb = v.strb; wlast = (i == int'(v.wlast_at));
         if (!dec) begin
            exp_w_q.push_back({wa, v.strb, d});
            exp_mem[wa] = merge(exp_mem[wa], d, v.strb);
         end
         #1; k = 0;
         while (!wready && k < 20) begin @(negedge aclk); #1; k++; end
         check("w_handshake", wready, 1);
         @(negedge aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      #1;
      check("b_latency", bvalid, 1);
      bready = 1'b1;
      k = 0;
      while (!bvalid && k < 20) begin @(negedge aclk); #1; k++; end
      @(negedge aclk);
      bready = 1'b0;
   endtask

   task automatic do_read(input vec_t v);
      int k, t0, cnt0;
      bit dec;
      logic [7:0] base, wa;
      dec  = addr_dec(v.addr);
      base = v.addr[9:2];
      for (int i = 0; i <= int'(v.len); i++) begin
         wa = base + 8'(i);
         exp_r_q.push_back({v.id, dec ? 32'h0 : exp_mem[wa], v.exp_resp, i == int'(v.len)});
      end
      cnt0 = rd_ce_cnt;
      @(negedge aclk);
      arid = v.id; araddr = v.addr; arlen = v.len; arvalid = 1'b1;
      #1; k = 0;
      while (!arready && k < 20) begin @(negedge aclk); #1; k++; end
      check("ar_handshake", arready, 1);
      t0 = cyc;
      @(negedge aclk);
      arvalid = 1'b0;
      for (int i = 0; i <= int'(v.len); i++) begin
         #1; k = 0;
         while (!rvalid && k < 20) begin @(negedge aclk); #1; k++; end
         check("r_valid", rvalid, 1);
         if (i == 0) check("r_first_latency", 64'(cyc - t0), 64'd3);
         for (int s = 0; s < v.stall; s++) begin
            check("r_stall_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, exp_r_q[0]});
            @(negedge aclk);
            #1;
         end
         rready = 1'b1;
         @(negedge aclk);
         rready = 1'b0;
      end
      check("r_ram_reads", 64'(rd_ce_cnt - cnt0), dec ? 64'd0 : 64'(int'(v.len) + 1));
   endtask

   initial begin
      int k, g;
      logic [2:0] order;
      vec_t tv;
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
      areset = 1'b1;
      awid = '0; awadr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
      wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arvalid = 1'b0; rready = 1'b0;

      //          wr    id     addr            len   burst  wl    data0           strb   stall resp
      vecs[0]  = '{1'b1, 4'd3, 32'h0000_0010, 4'd0, 2'b01, 4'd0, 32'hDEAD_BEEF, 4'hF, 0, OKAY};
      vecs[1]  = '{1'b0, 4'd5, 32'h0000_0010, 4'd0, 2'b01, 4'd0, 32'h0,         4'h0, 0, OKAY};
      vecs[2]  = '{1'b1, 4'd1, 32'h0000_03F8, 4'd3, 2'b01, 4'd3, 32'h1000_0000, 4'hF, 0, OKAY};
      vecs[3]  = '{1'b0, 4'd2, 32'h0000_03F8, 4'd3, 2'b01, 4'd0, 32'h0,         4'h0, 5, OKAY};
      vecs[4]  = '{1'b1, 4'd4, 32'h0000_0040, 4'd3, 2'b01, 4'd1, 32'h2000_0000, 4'hF, 0, SLVERR};
      vecs[5]  = '{1'b1, 4'd6, 32'h0000_0080, 4'd1, 2'b00, 4'd1, 32'h3300_0033, 4'h5, 0, OKAY};
      vecs[6]  = '{1'b0, 4'd7, 32'h0000_0080, 4'd0, 2'b01, 4'd0, 32'h0,         4'h0, 0, OKAY};
      vecs[7]  = '{1'b1, 4'd8, 32'h0000_0100, 4'd2, 2'b01, 4'd5, 32'h4000_0000, 4'hF, 0, SLVERR};
      vecs[8]  = '{1'b0, 4'd9, 32'h0001_0000, 4'd1, 2'b01, 4'd0, 32'h0,         4'h0, 0, HI_RESP};
      vecs[9]  = '{1'b1, 4'hA, 32'h0001_0044, 4'd0, 2'b01, 4'd0, 32'h5555_AAAA, 4'hF, 0, HI_RESP};
      vecs[10] = '{1'b0, 4'hB, 32'h0000_0044, 4'd0, 2'b01, 4'd0, 32'h0,         4'h0, 0, OKAY};

      repeat (2) @(negedge aclk);
      #1;
      check("reset_hs_outputs", 64'(hs_outs), 64'h0);
      check("reset_ram_outputs", 64'(ram_outs), 64'h0);
      check("reset_state", state_dbg, 3'd0);
      @(negedge aclk);
      areset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].wr) do_write(vecs[i]);
         else            do_read(vecs[i]);
      end

      // Reset after the second beat of a 4-beat write, with every request line active.
      @(negedge aclk);
      awid = 4'hC; awadr = 32'h200; awlen = 4'd3; awburst = 2'b01; awvalid = 1'b1;
      #1; k = 0;
      while (!awready && k < 20) begin @(negedge aclk); #1; k++; end
      check("rst_aw_handshake", awready, 1);
      @(negedge aclk);
      awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wvalid = 1'b1; wrdata = 32'h6000_0000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
         exp_w_q.push_back({8'h80 + 8'(i), 4'hF, wrdata});
         exp_mem[8'h80 + 8'(i)] = wrdata;
         #1;
         check("rst_w_handshake", wready, 1);
         @(negedge aclk);
      end
      wrdata = 32'h6000_0002; awvalid = 1'b1; arvalid = 1'b1; areset = 1'b1;
      #1;
      check("rst_mid_hs_outputs", 64'(hs_outs), 64'h0);
      check("rst_mid_ram_outputs", 64'(ram_outs), 64'h0);
      check("rst_mid_state", state_dbg, 3'd0);
      @(negedge aclk);
      areset = 1'b0; wvalid = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
      tv = '{1'b1, 4'hD, 32'h0000_0200, 4'd0, 2'b01, 4'd0, 32'h7777_0000, 4'hF, 0, OKAY};
      do_write(tv);
      tv = '{1'b0, 4'hE, 32'h0000_0200, 4'd1, 2'b01, 4'd0, 32'h0, 4'h0, 0, OKAY};
      do_read(tv);

      // Both address channels held from reset: expect write, read, write.
      @(negedge aclk);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0; bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      awid = 4'd7; awadr = 32'h100; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
      arid = 4'd8; araddr = 32'h10; arlen = 4'd0; arvalid = 1'b1;
      wvalid = 1'b1; wrdata = 32'hA5A5_0001; wstrb = 4'hF; wlast = 1'b1;
      g = 0; order = '0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (awready || arready) begin
            order[2 - g] = awready;
            if (awready) begin
               exp_w_q.push_back({8'h40, 4'hF, 32'hA5A5_0001});
               exp_b_q.push_back({4'd7, OKAY});
               exp_mem[8'h40] = 32'hA5A5_0001;
            end else begin
               exp_r_q.push_back({4'd8, exp_mem[8'h04], OKAY, 1'b1});
            end
            g++;
            if (g == 3) break;
         end
         @(negedge aclk);
      end
      check("arb_grant_count", 64'(g), 64'd3);
      check("arb_order", order, 3'b101);
      @(negedge aclk);
      awvalid = 1'b0; arvalid = 1'b0;
      #1; k = 0;
      while (!bvalid && k < 20) begin @(negedge aclk); #1; k++; end
      check("arb_final_b", bvalid, 1);
      @(negedge aclk);
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b0; rready = 1'b0;

      repeat (5) @(negedge aclk);
      #1;
      check("pending_ram_writes", 64'(exp_w_q.size()), 64'd0);
      check("pending_b", 64'(exp_b_q.size()), 64'd0);
      check("pending_r", 64'(exp_r_q.size()), 64'd0);
      check("end_state_idle", state_dbg, 3'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
